// File: rtl/mem_arbiter_ctrl_pkg.sv
// Shared CPU memory-system types for the cache/RAM arbiter.
// Includes RAM handshake states, arbiter FSM states and request sources.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'b00,
      BUSY   = 2'b01,
      ACCESS = 2'b10,
      ERROR  = 2'b11
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      IGRANT = 2'b01,
      DGRANT = 2'b10
   } arbstate_t;

   typedef enum logic {
      SRC_I = 1'b0,
      SRC_D = 1'b1
   } arbsrc_t;

endpackage

// File: rtl/mem_arbiter_ctrl_if.sv
// caches_if: icache/dcache request bundle plus the single-port RAM port.
// The slave modport is the arbiter; the master modport is the caches and RAM together.
interface caches_if
   import cpu_types_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              iREN;
   logic [ADDR_W-1:0] iaddr;
   logic              iwait;
   logic [DATA_W-1:0] iload;

   logic              dREN;
   logic              dWEN;
   logic [ADDR_W-1:0] daddr;
   logic [DATA_W-1:0] dstore;
   logic              dwait;
   logic [DATA_W-1:0] dload;

   logic              ramREN;
   logic              ramWEN;
   logic [ADDR_W-1:0] ramaddr;
   logic [DATA_W-1:0] ramstore;
   logic [DATA_W-1:0] ramload;
   ramstate_t         ramstate;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
   );
endinterface

// File: rtl/mem_arbiter_ctrl_pick.sv
// mem_arb_pick: chooses which cache is granted next.
// Default is fixed dcache priority; with ARB_FAIR_EN ties alternate via a last_grant flop.
module mem_arb_pick
   import cpu_types_pkg::*;
(
`ifdef ARB_FAIR_EN
   input  logic    CLK,
   input  logic    nRST,
   input  logic    take,
`endif
   input  logic    i_req,
   input  logic    d_req,
   output logic    any,
   output arbsrc_t winner
);

`ifdef ARB_FAIR_EN
   arbsrc_t last_grant;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         last_grant <= SRC_I;
      else if (take)
         last_grant <= winner;
   end

   always_comb begin
      any    = i_req | d_req;
      winner = d_req ? SRC_D : SRC_I;
      // On a tie, serve whichever source did not win last time.
      if (i_req && d_req)
         winner = (last_grant == SRC_I) ? SRC_D : SRC_I;
   end
`else
   always_comb begin
      any    = i_req | d_req;
      winner = d_req ? SRC_D : SRC_I;
   end
`endif

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// mem_arbiter_ctrl: arbitrates icache and dcache requests onto one single-port RAM.
// Optional round-robin tie breaking is enabled by defining ARB_FAIR_EN.
module mem_arbiter_ctrl
   import cpu_types_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
)(
   input logic     CLK,
   input logic     nRST,
   caches_if.slave cif
);

   arbstate_t         state;
   logic              lat_write;
   logic              ram_ren;
   logic              ram_wen;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_store;

   logic    i_req, d_req, any;
   arbsrc_t winner;
   logic    i_done, d_done;

   assign i_req = cif.iREN;
   assign d_req = cif.dREN | cif.dWEN;

   mem_arb_pick u_pick (
`ifdef ARB_FAIR_EN
      .CLK    (CLK),
      .nRST   (nRST),
      .take   (state == IDLE && any),
`endif
      .i_req  (i_req),
      .d_req  (d_req),
      .any    (any),
      .winner (winner)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state     <= IDLE;
         lat_write <= 1'b0;
         ram_ren   <= 1'b0;
         ram_wen   <= 1'b0;
         ram_addr  <= '0;
         ram_store <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any && winner == SRC_D) begin
                  state     <= DGRANT;
                  lat_write <= cif.dWEN;
                  ram_ren   <= ~cif.dWEN;
                  ram_wen   <= cif.dWEN;
                  ram_addr  <= cif.daddr;
                  ram_store <= cif.dstore;
               end else if (any) begin
                  state     <= IGRANT;
                  lat_write <= 1'b0;
                  ram_ren   <= 1'b1;
                  ram_wen   <= 1'b0;
                  ram_addr  <= cif.iaddr;
                  ram_store <= '0;
               end
            end
            // Completion and requester abort both return to IDLE with enables dropped.
            IGRANT: begin
               if (!i_req || cif.ramstate == ACCESS) begin
                  state   <= IDLE;
                  ram_ren <= 1'b0;
                  ram_wen <= 1'b0;
               end
            end
            DGRANT: begin
               if (!d_req || cif.ramstate == ACCESS) begin
                  state   <= IDLE;
                  ram_ren <= 1'b0;
                  ram_wen <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               ram_ren <= 1'b0;
               ram_wen <= 1'b0;
            end
         endcase
      end
   end

   assign i_done = (state == IGRANT) && i_req && (cif.ramstate == ACCESS);
   assign d_done = (state == DGRANT) && d_req && (cif.ramstate == ACCESS);

   assign cif.iwait    = ~i_done;
   assign cif.iload    = i_done ? cif.ramload : '0;
   assign cif.dwait    = ~d_done;
   assign cif.dload    = (d_done && !lat_write) ? cif.ramload : '0;
   assign cif.ramREN   = ram_ren;
   assign cif.ramWEN   = ram_wen;
   assign cif.ramaddr  = ram_addr;
   assign cif.ramstore = ram_store;

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Directed self-checking bench for mem_arbiter_ctrl (default build, fixed dcache priority).
// A word-addressed RAM model answers reads combinationally and commits writes on ACCESS.
module tb_mem_arbiter_ctrl;
   import cpu_types_pkg::*;

   logic CLK = 1'b0;
   logic nRST;
   int   tests = 0;
   int   fails = 0;

   logic [31:0] mem [256];

   caches_if #(.ADDR_W(32), .DATA_W(32)) cif ();

   mem_arbiter_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .cif  (cif)
   );

   always #5 CLK = ~CLK;

   assign cif.ramload = mem[cif.ramaddr[9:2]];

   always @(posedge CLK)
      if (cif.ramWEN && cif.ramstate == ACCESS)
         mem[cif.ramaddr[9:2]] <= cif.ramstore;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      nRST          = 1'b0;
      cif.iREN      = 1'b0;
      cif.iaddr     = '0;
      cif.dREN      = 1'b0;
      cif.dWEN      = 1'b0;
      cif.daddr     = '0;
      cif.dstore    = '0;
      cif.ramstate  = FREE;
      for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 + i;
      tick();
      @(negedge CLK);
      tests++;
      if ({cif.ramREN, cif.ramWEN, cif.iwait, cif.dwait} !== 4'b0011) begin
         fails++;
         $display("FAIL reset_ctrl: got %b want 0011", {cif.ramREN, cif.ramWEN, cif.iwait, cif.dwait});
      end
      tests++;
      if ({cif.ramaddr, cif.ramstore, cif.iload, cif.dload} !== 128'h0) begin
         fails++;
         $display("FAIL reset_data: got %h want 0", {cif.ramaddr, cif.ramstore, cif.iload, cif.dload});
      end
      nRST = 1'b1;
      tick();
   endtask

   task automatic test_iread_busy();
      cif.iREN = 1'b1; cif.iaddr = 32'h40; cif.ramstate = BUSY;
      @(negedge CLK);
      tests++;
      if ({cif.ramREN, cif.iwait} !== 2'b01) begin
         fails++;
         $display("FAIL i_req_cycle: got %b want 01", {cif.ramREN, cif.iwait});
      end
      for (int k = 0; k < 2; k++) begin
         tick();
         @(negedge CLK);
         tests++;
         if ({cif.ramREN, cif.iwait, cif.ramaddr} !== {2'b11, 32'h40}) begin
            fails++;
            $display("FAIL i_busy%0d: got %b %h want 11 00000040", k, {cif.ramREN, cif.iwait}, cif.ramaddr);
         end
      end
      tick();
      cif.ramstate = ACCESS;
      @(negedge CLK);
      tests++;
      if ({cif.iwait, cif.dwait, cif.iload} !== {2'b01, 32'hA500_0010}) begin
         fails++;
         $display("FAIL i_done: got %b %h want 01 a5000010", {cif.iwait, cif.dwait}, cif.iload);
      end
      tick();
      cif.iREN = 1'b0; cif.ramstate = FREE;
      @(negedge CLK);
      tests++;
      if ({cif.ramREN, cif.iwait} !== 2'b01) begin
         fails++;
         $display("FAIL i_one_cycle: got %b want 01", {cif.ramREN, cif.iwait});
      end
      tick();
   endtask

   task automatic test_write_then_read();
      cif.dWEN = 1'b1; cif.daddr = 32'h80; cif.dstore = 32'hDEAD_BEEF; cif.ramstate = ACCESS;
      @(negedge CLK);
      tests++;
      if ({cif.ramWEN, cif.dwait} !== 2'b01) begin
         fails++;
         $display("FAIL w_req_cycle: got %b want 01", {cif.ramWEN, cif.dwait});
      end
      tick();
      @(negedge CLK);
      tests++;
      if ({cif.ramREN, cif.ramWEN, cif.dwait, cif.ramstore, cif.dload} !== {3'b010, 32'hDEAD_BEEF, 32'h0}) begin
         fails++;
         $display("FAIL w_grant: got %b %h %h want 010 deadbeef 0",
                  {cif.ramREN, cif.ramWEN, cif.dwait}, cif.ramstore, cif.dload);
      end
      tick();
      cif.dWEN = 1'b0; cif.dREN = 1'b1;
      @(negedge CLK);
      tests++;
      if ({cif.ramREN, cif.ramWEN, cif.dwait} !== 3'b001) begin
         fails++;
         $display("FAIL w_bubble: got %b want 001", {cif.ramREN, cif.ramWEN, cif.dwait});
      end
      tick();
      @(negedge CLK);
      tests++;
      if ({cif.ramREN, cif.ramWEN, cif.dwait, cif.dload} !== {3'b100, 32'hDEAD_BEEF}) begin
         fails++;
         $display("FAIL r_after_w: got %b %h want 100 deadbeef", {cif.ramREN, cif.ramWEN, cif.dwait}, cif.dload);
      end
      tick();
      cif.dREN = 1'b0;
      tick();
   endtask

   task automatic test_tie_priority();
      cif.iREN = 1'b1; cif.iaddr = 32'h44; cif.dREN = 1'b1; cif.daddr = 32'h80; cif.ramstate = ACCESS;
      @(negedge CLK);
      tests++;
      if ({cif.iwait, cif.dwait} !== 2'b11) begin
         fails++;
         $display("FAIL tie_req_cycle: got %b want 11", {cif.iwait, cif.dwait});
      end
      tick();
      @(negedge CLK);
      tests++;
      if ({cif.iwait, cif.dwait, cif.ramaddr, cif.dload} !== {2'b10, 32'h80, 32'hDEAD_BEEF}) begin
         fails++;
         $display("FAIL tie_d_first: got %b %h %h want 10 00000080 deadbeef",
                  {cif.iwait, cif.dwait}, cif.ramaddr, cif.dload);
      end
      tick();
      cif.dREN = 1'b0;
      @(negedge CLK);
      tests++;
      if ({cif.ramREN, cif.iwait, cif.dwait} !== 3'b011) begin
         fails++;
         $display("FAIL tie_bubble: got %b want 011", {cif.ramREN, cif.iwait, cif.dwait});
      end
      tick();
      @(negedge CLK);
      tests++;
      if ({cif.iwait, cif.dwait, cif.ramaddr, cif.iload} !== {2'b01, 32'h44, 32'hA500_0011}) begin
         fails++;
         $display("FAIL tie_i_second: got %b %h %h want 01 00000044 a5000011",
                  {cif.iwait, cif.dwait}, cif.ramaddr, cif.iload);
      end
      tick();
      cif.iREN = 1'b0;
      tick();
   endtask

   task automatic test_ram_error();
      cif.dREN = 1'b1; cif.daddr = 32'h48; cif.ramstate = ERROR;
      tick();
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         tests++;
         if ({cif.ramREN, cif.dwait, cif.ramaddr} !== {2'b11, 32'h48}) begin
            fails++;
            $display("FAIL err_hold%0d: got %b %h want 11 00000048", k, {cif.ramREN, cif.dwait}, cif.ramaddr);
         end
         tick();
      end
      cif.ramstate = ACCESS;
      @(negedge CLK);
      tests++;
      if ({cif.dwait, cif.dload} !== {1'b0, 32'hA500_0012}) begin
         fails++;
         $display("FAIL err_done: got %b %h want 0 a5000012", cif.dwait, cif.dload);
      end
      tick();
      cif.dREN = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_grant();
      cif.iREN = 1'b1; cif.iaddr = 32'h4C; cif.ramstate = BUSY;
      tick();
      @(negedge CLK);
      tests++;
      if (cif.ramREN !== 1'b1) begin
         fails++;
         $display("FAIL rst_pre_grant: got %b want 1", cif.ramREN);
      end
      nRST = 1'b0;
      #1;
      tests++;
      if ({cif.ramREN, cif.iwait, cif.ramaddr} !== {2'b01, 32'h0}) begin
         fails++;
         $display("FAIL rst_abandon: got %b %h want 01 00000000", {cif.ramREN, cif.iwait}, cif.ramaddr);
      end
      #1;
      nRST = 1'b1;
      tick();
      cif.ramstate = ACCESS;
      @(negedge CLK);
      tests++;
      if ({cif.iwait, cif.iload} !== {1'b0, 32'hA500_0013}) begin
         fails++;
         $display("FAIL rst_rerequest: got %b %h want 0 a5000013", cif.iwait, cif.iload);
      end
      tick();
      cif.iREN = 1'b0;
      tick();
   endtask

   task automatic test_abort();
      cif.iREN = 1'b1; cif.iaddr = 32'h50; cif.ramstate = BUSY;
      tick();
      cif.iREN = 1'b0; cif.dREN = 1'b1; cif.daddr = 32'h54; cif.ramstate = ACCESS;
      @(negedge CLK);
      tests++;
      if ({cif.ramREN, cif.iwait, cif.dwait} !== 3'b111) begin
         fails++;
         $display("FAIL abort_no_pulse: got %b want 111", {cif.ramREN, cif.iwait, cif.dwait});
      end
      tick();
      @(negedge CLK);
      tests++;
      if ({cif.ramREN, cif.iwait, cif.dwait} !== 3'b011) begin
         fails++;
         $display("FAIL abort_idle: got %b want 011", {cif.ramREN, cif.iwait, cif.dwait});
      end
      tick();
      @(negedge CLK);
      tests++;
      if ({cif.ramREN, cif.dwait, cif.ramaddr, cif.dload} !== {2'b10, 32'h54, 32'hA500_0015}) begin
         fails++;
         $display("FAIL abort_d_grant: got %b %h %h want 10 00000054 a5000015",
                  {cif.ramREN, cif.dwait}, cif.ramaddr, cif.dload);
      end
      tick();
      cif.dREN = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_iread_busy();
      test_write_then_read();
      test_tie_priority();
      test_ram_error();
      test_reset_mid_grant();
      test_abort();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
